// File: rtl/stopwatch_lap_core.sv
// Light-sensor stopwatch: debounced start/stop, lap hold, mixed-radix BCD count.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above sec ones on o_seg.
module stopwatch_lap_core #(
  parameter int CLOCK_FREQ      = 50_000_000,
  parameter int TICK_HZ         = 100,
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit COMMON_ANODE    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sensor,
  input  logic                    clr,
  input  logic                    lap,
  output logic                    led0,
  output logic                    o_running,
  output logic                    o_lap_hold,
  output logic                    o_overflow,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic [7*NUM_DIGITS-1:0] o_seg
);

  localparam int F   = (TICK_HZ == 100) ? 2 : (TICK_HZ == 10) ? 1 : 0;
  localparam int DIV = CLOCK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW  = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (TICK_HZ != 1 && TICK_HZ != 10 && TICK_HZ != 100) begin : g_bad_tick
      $error("TICK_HZ must be 1, 10 or 100");
    end
    if (NUM_DIGITS < F + 5) begin : g_bad_digits
      $error("NUM_DIGITS too small for the fraction digits");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  function automatic logic [3:0] dig_max(input int i);
    if (i == F + 1 || i == F + 3) return 4'd5;
    return 4'd9;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  state_t          r_state;
  state_t          w_state_nx;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_db_cnt;
  logic            r_level;
  logic [PW-1:0]   r_pre;
  logic [BW-1:0]   r_count;
  logic [BW-1:0]   r_lap;
  logic [BW-1:0]   r_bcd;
  logic            r_hold;
  logic            r_ovf;
  logic            r_lap_d;
  logic            w_accept;
  logic            w_s_evt;
  logic            w_run;
  logic            w_clr;
  logic            w_tick;
  logic            w_lap_edge;
  logic            w_all_max;
  logic [BW-1:0]   w_inc;
  logic [BW-1:0]   w_cnt_nx;
  logic [NUM_DIGITS:0]   w_carry;
  logic [NUM_DIGITS-1:0] w_blank;

  // a level is accepted once the synchronised input has differed DEBOUNCE_CYCLES times in a row
  assign w_accept = (r_sync[1] != r_level) && (r_db_cnt == DB_MAX);
  assign w_s_evt  = w_accept && r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], sensor};
      if (r_sync[1] == r_level || w_accept) r_db_cnt <= '0;
      else r_db_cnt <= r_db_cnt + 1'b1;
      if (w_accept) r_level <= r_sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (clr) w_state_nx = S_IDLE;
               else if (w_s_evt) w_state_nx = S_RUN;
      S_RUN:   if (w_s_evt) w_state_nx = S_STOP;
      S_STOP:  if (clr) w_state_nx = S_IDLE;
               else if (w_s_evt) w_state_nx = S_RUN;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_run      = (r_state == S_RUN);
  assign w_clr      = clr && !w_run;
  assign w_tick     = w_run && (r_pre == PRE_MAX);
  assign w_lap_edge = lap && !r_lap_d;

  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    w_inc      = r_count;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry[i]) begin
        if (r_count[4*i +: 4] == dig_max(i)) begin
          w_inc[4*i +: 4] = 4'd0;
          w_carry[i+1]    = 1'b1;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  // carry out of the top digit means every digit sits at its maximum
  assign w_all_max = w_carry[NUM_DIGITS];
  assign w_cnt_nx  = (w_tick && !w_all_max) ? w_inc : r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_clr) begin
      r_pre   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_run) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick && !w_all_max) r_count <= w_inc;
      if (w_tick && w_all_max) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_d <= 1'b0;
      r_lap   <= '0;
      r_hold  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_lap_d <= lap;
      r_bcd   <= r_hold ? r_lap : r_count;
      if (w_clr) begin
        r_lap  <= '0;
        r_hold <= 1'b0;
      end else if (w_lap_edge) begin
        if (r_hold) begin
          r_hold <= 1'b0;
        end else if (w_run) begin
          r_lap  <= w_cnt_nx;
          r_hold <= 1'b1;
        end
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS:F+1] w_lead;
  always_comb begin
    w_lead             = '0;
    w_lead[NUM_DIGITS] = 1'b1;
    w_blank            = '0;
    for (int i = NUM_DIGITS - 1; i > F; i--) begin
      w_lead[i]  = w_lead[i+1] && (r_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = w_lead[i];
    end
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    o_seg = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      o_seg[7*i +: 7] = (w_blank[i] ? 7'h00 : glyph(r_bcd[4*i +: 4]))
                        ^ {7{COMMON_ANODE}};
    end
  end

  assign led0       = r_level;
  assign o_running  = w_run;
  assign o_lap_hold = r_hold;
  assign o_overflow = r_ovf;
  assign o_bcd      = r_bcd;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Bench for stopwatch_lap_core: timed stimulus with a queue of expected o_bcd values.
// DIV=10, 8 digits, debounce 4; counts are preloaded hierarchically where runs would be long.
module tb_stopwatch_lap_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sensor;
  logic        clr;
  logic        lap;
  logic        led0;
  logic        o_running;
  logic        o_lap_hold;
  logic        o_overflow;
  logic [31:0] o_bcd;
  logic [55:0] o_seg;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  stopwatch_lap_core #(
    .CLOCK_FREQ(1000),
    .TICK_HZ(100),
    .NUM_DIGITS(8),
    .DEBOUNCE_CYCLES(4),
    .COMMON_ANODE(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sensor(sensor),
    .clr(clr),
    .lap(lap),
    .led0(led0),
    .o_running(o_running),
    .o_lap_hold(o_lap_hold),
    .o_overflow(o_overflow),
    .o_bcd(o_bcd),
    .o_seg(o_seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk(tag, 64'(got), 64'(e));
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sevt();
    sensor = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    sensor = 1'b0;
  endtask

  function automatic logic [55:0] seg_model(input logic [31:0] b);
    logic [55:0] s;
    logic [6:0]  g;
    logic [3:0]  d;
    logic        lead;
    s    = '0;
    lead = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      d = b[4*i +: 4];
      case (d)
        4'd0: g = 7'h3F;  4'd1: g = 7'h06;  4'd2: g = 7'h5B;
        4'd3: g = 7'h4F;  4'd4: g = 7'h66;  4'd5: g = 7'h6D;
        4'd6: g = 7'h7D;  4'd7: g = 7'h07;  4'd8: g = 7'h7F;
        4'd9: g = 7'h6F;  default: g = 7'h00;
      endcase
      lead = lead && (d == 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 2 && lead) g = 7'h00;
`endif
      s[7*i +: 7] = g;
    end
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, r, e, c, d, e2, g, h, e3, k, p, l, e4;
    rst_n  = 1'b0;
    sensor = 1'b0;
    clr    = 1'b0;
    lap    = 1'b0;
    #2;
    chk("rst_running", 64'(o_running), 64'd0);
    chk("rst_led0", 64'(led0), 64'd0);
    chk("rst_hold", 64'(o_lap_hold), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_seg", 64'(o_seg), 64'(seg_model(32'h0)));
    exp_q.push_back(32'h0);
    sb_check("rst_bcd", o_bcd);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    x = cyc;
    sensor = 1'b1;
    wait_to(x + 3);
    sensor = 1'b0;
    wait_to(x + 15);
    chk("short_pulse_run", 64'(o_running), 64'd0);
    chk("short_pulse_led", 64'(led0), 64'd0);

    r = cyc;
    sensor = 1'b1;
    wait_to(r + 5);
    chk("evt_early", 64'(o_running), 64'd0);
    wait_to(r + 6);
    chk("evt_run", 64'(o_running), 64'd1);
    chk("evt_led0", 64'(led0), 64'd1);
    e = r + 6;
    wait_to(r + 8);
    sensor = 1'b0;

    exp_q.push_back(32'h0000_0999);
    wait_to(e + 10000);
    sb_check("t999", o_bcd);
    exp_q.push_back(32'h0000_1000);
    wait_to(e + 10001);
    sb_check("t1000", o_bcd);
    wait_to(e + 10003);
    sevt();
    chk("stop1", 64'(o_running), 64'd0);

    c = e + 10020;
    wait_to(c);
    clr = 1'b1;
    exp_q.push_back(32'h0000_1000);
    wait_to(c + 1);
    clr = 1'b0;
    sb_check("clr_latency", o_bcd);
    exp_q.push_back(32'h0);
    wait_to(c + 2);
    sb_check("clr_bcd", o_bcd);
    chk("clr_idle", 64'(o_running), 64'd0);

    d = c + 5;
    wait_to(d);
    dut.r_count = 32'h0000_5999;
    sevt();
    e2 = d + 6;
    exp_q.push_back(32'h0000_5999);
    wait_to(e2 + 10);
    sb_check("pre_5999", o_bcd);
    exp_q.push_back(32'h0001_0000);
    wait_to(e2 + 11);
    sb_check("min_carry", o_bcd);
    wait_to(e2 + 12);
    sevt();

    wait_to(e2 + 30);
    dut.r_count = 32'h9959_5999;
    g = e2 + 32;
    wait_to(g);
    sevt();
    wait_to(g + 7);
    chk("ovf_before", 64'(o_overflow), 64'd0);
    wait_to(g + 8);
    chk("ovf_set", 64'(o_overflow), 64'd1);
    exp_q.push_back(32'h9959_5999);
    wait_to(g + 9);
    sb_check("ovf_sat", o_bcd);
    wait_to(g + 14);
    sevt();
    chk("ovf_stop", 64'(o_running), 64'd0);
    exp_q.push_back(32'h9959_5999);
    sb_check("ovf_hold", o_bcd);
    wait_to(g + 30);
    clr = 1'b1;
    wait_to(g + 31);
    clr = 1'b0;
    chk("ovf_clr", 64'(o_overflow), 64'd0);
    exp_q.push_back(32'h0);
    wait_to(g + 32);
    sb_check("ovf_clr_bcd", o_bcd);

    h = g + 40;
    wait_to(h);
    sevt();
    e3 = h + 6;
    wait_to(e3 + 5227);
    sevt();
    chk("stop523", 64'(o_running), 64'd0);
    exp_q.push_back(32'h0000_0523);
    sb_check("stop523_bcd", o_bcd);
    k = e3 + 5283;
    wait_to(k);
    exp_q.push_back(32'h0000_0523);
    sb_check("stop_hold", o_bcd);
    sevt();
    p = k + 6;
    exp_q.push_back(32'h0000_0523);
    wait_to(p + 7);
    sb_check("resume_wait", o_bcd);
    exp_q.push_back(32'h0000_0524);
    wait_to(p + 8);
    sb_check("resume_tick", o_bcd);
    wait_to(p + 9);
    clr = 1'b1;
    wait_to(p + 10);
    clr = 1'b0;
    wait_to(p + 12);
    chk("clr_in_run", 64'(o_running), 64'd1);
    exp_q.push_back(32'h0000_0524);
    sb_check("clr_in_run_bcd", o_bcd);
    sevt();
    exp_q.push_back(32'h0000_0525);
    wait_to(p + 19);
    sb_check("stop525", o_bcd);
    wait_to(p + 25);
    clr = 1'b1;
    wait_to(p + 26);
    clr = 1'b0;
    exp_q.push_back(32'h0);
    wait_to(p + 27);
    sb_check("clr_stop_bcd", o_bcd);
    chk("clr_stop_idle", 64'(o_running), 64'd0);
    wait_to(p + 30);
    lap = 1'b1;
    wait_to(p + 31);
    lap = 1'b0;
    wait_to(p + 32);
    chk("lap_idle", 64'(o_lap_hold), 64'd0);

    l = p + 35;
    wait_to(l);
    sevt();
    e4 = l + 6;
    wait_to(e4 + 2499);
    lap = 1'b1;
    exp_q.push_back(32'h0000_0250);
    wait_to(e4 + 2501);
    lap = 1'b0;
    sb_check("lap_capture", o_bcd);
    chk("lap_hold_on", 64'(o_lap_hold), 64'd1);
    exp_q.push_back(32'h0000_0250);
    wait_to(e4 + 2700);
    sb_check("lap_frozen", o_bcd);
    lap = 1'b1;
    wait_to(e4 + 2701);
    lap = 1'b0;
    exp_q.push_back(32'h0000_0270);
    wait_to(e4 + 2702);
    sb_check("lap_release", o_bcd);
    chk("lap_hold_off", 64'(o_lap_hold), 64'd0);

    wait_to(e4 + 2703);
    sevt();
    wait_to(e4 + 2730);
    dut.r_count = 32'h0000_0305;
    exp_q.push_back(32'h0000_0305);
    wait_to(e4 + 2732);
    sb_check("seg_bcd", o_bcd);
    chk("seg_305", 64'(o_seg), 64'(seg_model(32'h0000_0305)));

    wait_to(e4 + 2740);
    dut.r_count = 32'h0000_1234;
    wait_to(e4 + 2745);
    sensor = 1'b1;
    wait_to(e4 + 2754);
    chk("pre_rst_run", 64'(o_running), 64'd1);
    chk("pre_rst_led0", 64'(led0), 64'd1);
    exp_q.push_back(32'h0000_1235);
    sb_check("pre_rst_bcd", o_bcd);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_running", 64'(o_running), 64'd0);
    chk("arst_led0", 64'(led0), 64'd0);
    chk("arst_hold", 64'(o_lap_hold), 64'd0);
    chk("arst_ovf", 64'(o_overflow), 64'd0);
    chk("arst_seg", 64'(o_seg), 64'(seg_model(32'h0)));
    exp_q.push_back(32'h0);
    sb_check("arst_bcd", o_bcd);
    sensor = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    sb_check("post_rst_bcd", o_bcd);
    chk("post_rst_run", 64'(o_running), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
